dma_priority_resolver: RTL and testbench
========================================

# dma_priority_resolver

Per-channel request arbiter sitting directly upstream of `timingAndControl` in the 4-channel DMA controller. Samples the DREQ pins, applies polarity, mask and software requests, and picks one winning channel (fixed or rotating priority). Holds that grant stable to `timingAndControl` until service ends. On release it updates the rotation pointer and clears the serviced channel's software request.

## Interface
Parameters:
- `SYNC_STAGES`, default 1: DREQ input register depth. Legal values are 1 or 2.

Ports:
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `DREQ`  in  4  raw channel request pins.
- `dreqSenseLow`  in  1  command-register bit: DREQ is active low when 1.
- `rotatingPriority`  in  1  command-register bit: 1 = rotating priority, 0 = fixed priority.
- `controllerDisable`  in  1  command-register bit: blocks new grants.
- `maskReg`  in  4  per-channel mask; 1 = hardware DREQ ignored.
- `swRequestReg`  in  4  software request bits; not maskable.
- `releaseGrant`  in  1  one-cycle pulse from `timingAndControl` at end of service (EOP or end of transfer).
- `requestValid`  out  1  a grant is presented.
- `grantOneHot`  out  4  granted channel, one-hot.
- `grantIndex`  out  2  granted channel number.
- `clearSwRequest`  out  4  one-cycle pulse that clears the serviced channel's software request bit.
- `priorityPointer`  out  2  current highest-priority channel (status).

## Operation
- Synchronised request: `dreqQ` = DREQ delayed by `SYNC_STAGES` registers.
- Effective request vector: `effReq = ((dreqQ ^ {4{dreqSenseLow}}) & ~maskReg) | swRequestReg`.
- Search order:
  - Rotating priority: starts at `priorityPointer` and ascends modulo 4.
  - Fixed priority: 0, 1, 2, 3. While `rotatingPriority`=0, the pointer is forced to 0 every cycle.
- FSM states: IDLE, GRANTED, RELEASE.
  - IDLE: if `effReq`≠0 and `controllerDisable`=0, latch the winner into `grantIndex`/`grantOneHot`, set `requestValid`, and go to GRANTED. Otherwise stay in IDLE.
  - GRANTED: the grant is frozen. Changes to DREQ, mask, swRequest or `controllerDisable` have no effect. On `releaseGrant`:
    - `requestValid` drops.
    - `clearSwRequest[grantIndex]` pulses for one cycle.
    - If rotating, the pointer becomes `grantIndex+1` (2-bit wrap, so 3→0).
    - Go to RELEASE.
  - RELEASE: one dead cycle with `requestValid`=0. The next arbitration sees the updated pointer and the cleared software request. Always returns to IDLE.
- `releaseGrant` is ignored in IDLE and RELEASE.
- Reset values: state IDLE; `requestValid`=0; `grantOneHot`=0000; `grantIndex`=0; `clearSwRequest`=0000; `priorityPointer`=0; sync registers cleared.

## Timing
- A DREQ level stable before rising edge k appears in `dreqQ` after edge k+SYNC_STAGES-1. `requestValid` and the grant are valid after edge k+SYNC_STAGES.
- `swRequestReg` bypasses the sync registers: set before edge k, granted after edge k.
- `releaseGrant` high at edge r:
  - `requestValid`=0 and the `clearSwRequest` pulse after r.
  - State is RELEASE during cycle r+1.
  - The earliest new grant is after edge r+2.
- Minimum gap between grants is 2 cycles (one RELEASE cycle plus one IDLE cycle).
- Simultaneous requests are resolved purely by search order in a single cycle.
- A DREQ dropping while GRANTED does not remove the grant; `timingAndControl` handles it.
- RESET in any state takes effect at the next edge: grant dropped, no `clearSwRequest` pulse, pointer returns to 0.

## Structure
- Package `dma_priority_pkg`:
  - `NUM_CHANNELS`=4.
  - `typedef logic [1:0] channel_t`.
  - `typedef enum {IDLE, GRANTED, RELEASE} resolverState_t`.
- Sub-module `rotating_priority_encoder`: combinational. Inputs `req[3:0]` and pointer; outputs winner index and any-valid. Used for both fixed mode (pointer 0) and rotating mode.

## Test plan
- Reset, then DREQ=0001, mask=0000, SYNC_STAGES=1 → after 2 edges `requestValid`=1, `grantIndex`=0, `grantOneHot`=0001.
- Fixed mode, DREQ=1010 → grant ch1. Pulse `releaseGrant` → RELEASE, then ch1 is granted again (2-cycle gap); pointer stays 0.
- Rotating mode, DREQ=1111:
  - Successive releases grant channels 0, 1, 2, 3, 0.
  - `priorityPointer` reads 1, 2, 3, 0 after each release (wrap checked).
- `maskReg`=0001, DREQ=0001, swRequestReg=0000 → no grant. Then swRequestReg=0001 → ch0 granted next edge; on release `clearSwRequest`=0001 for exactly one cycle.
- Polarity and disable:
  - `dreqSenseLow`=1 with DREQ=1110 → ch0 granted.
  - Asserting `controllerDisable` while GRANTED keeps the grant.
  - After release with disable still high → no new grant.
- RESET pulse in GRANTED with ch2 granted → next edge all outputs 0, pointer 0, no `clearSwRequest` pulse.

Source files
------------

// File: rtl/dma_priority_pkg.sv
// Shared types and helpers for the DMA channel priority resolver.
package dma_priority_pkg;

    localparam int unsigned NUM_CHANNELS = 4;

    typedef logic [1:0]              channel_t;
    typedef logic [NUM_CHANNELS-1:0] chanvec_t;

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        RELEASE
    } resolverState_t;

    function automatic chanvec_t channel_onehot(input channel_t ch);
        return chanvec_t'(1) << ch;
    endfunction

endpackage

// File: rtl/dma_priority_resolver_encoder.sv
// Combinational priority search over the request vector, starting at the pointer and
// ascending modulo the channel count.
module rotating_priority_encoder
    import dma_priority_pkg::*;
(
    input  logic [NUM_CHANNELS-1:0] req,
    input  logic [1:0]              pointer,
    output logic [1:0]              winner,
    output logic                    anyValid
);

    channel_t cand;

    // Walk from the lowest-priority offset upward so the highest-priority hit is written last.
    always_comb begin
        winner   = pointer;
        anyValid = 1'b0;
        cand     = pointer;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            cand = pointer + channel_t'(i);
            if (req[cand]) begin
                winner   = cand;
                anyValid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_priority_resolver.sv
// Four-channel DREQ arbiter: synchronises requests, picks a fixed or rotating-priority
// winner and holds it until the transfer controller releases it.
module dma_priority_resolver
    import dma_priority_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] DREQ,
    input  logic       dreqSenseLow,
    input  logic       rotatingPriority,
    input  logic       controllerDisable,
    input  logic [3:0] maskReg,
    input  logic [3:0] swRequestReg,
    input  logic       releaseGrant,
    output logic       requestValid,
    output logic [3:0] grantOneHot,
    output logic [1:0] grantIndex,
    output logic [3:0] clearSwRequest,
    output logic [1:0] priorityPointer
);

    chanvec_t syncQ [SYNC_STAGES];
    chanvec_t dreqQ;
    chanvec_t effReq;
    channel_t searchPointer;
    channel_t winner;
    logic     anyValid;

    resolverState_t stateQ, stateD;
    logic     validQ, validD;
    chanvec_t oneHotQ, oneHotD;
    channel_t indexQ, indexD;
    chanvec_t clearQ, clearD;
    channel_t pointerQ, pointerD;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                syncQ[i] <= '0;
            end
        end else begin
            syncQ[0] <= DREQ;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                syncQ[i] <= syncQ[i-1];
            end
        end
    end

    assign dreqQ  = syncQ[SYNC_STAGES-1];
    // Software requests bypass both the mask and the synchroniser.
    assign effReq = ((dreqQ ^ {NUM_CHANNELS{dreqSenseLow}}) & ~maskReg) | swRequestReg;
    assign searchPointer = rotatingPriority ? pointerQ : '0;

    rotating_priority_encoder u_encoder (
        .req      (effReq),
        .pointer  (searchPointer),
        .winner   (winner),
        .anyValid (anyValid)
    );

    always_comb begin
        stateD   = stateQ;
        validD   = validQ;
        oneHotD  = oneHotQ;
        indexD   = indexQ;
        clearD   = '0;
        pointerD = pointerQ;

        unique case (stateQ)
            IDLE: begin
                if (anyValid && !controllerDisable) begin
                    validD  = 1'b1;
                    indexD  = winner;
                    oneHotD = channel_onehot(winner);
                    stateD  = GRANTED;
                end
            end
            GRANTED: begin
                if (releaseGrant) begin
                    validD  = 1'b0;
                    oneHotD = '0;
                    indexD  = '0;
                    clearD  = channel_onehot(indexQ);
                    if (rotatingPriority) begin
                        pointerD = indexQ + channel_t'(1);
                    end
                    stateD  = RELEASE;
                end
            end
            RELEASE: begin
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase

        if (!rotatingPriority) begin
            pointerD = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stateQ   <= IDLE;
            validQ   <= 1'b0;
            oneHotQ  <= '0;
            indexQ   <= '0;
            clearQ   <= '0;
            pointerQ <= '0;
        end else begin
            stateQ   <= stateD;
            validQ   <= validD;
            oneHotQ  <= oneHotD;
            indexQ   <= indexD;
            clearQ   <= clearD;
            pointerQ <= pointerD;
        end
    end

    assign requestValid    = validQ;
    assign grantOneHot     = oneHotQ;
    assign grantIndex      = indexQ;
    assign clearSwRequest  = clearQ;
    assign priorityPointer = pointerQ;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Directed and randomised checks of dma_priority_resolver against a cycle-level reference model.
module tb_dma_priority_resolver;

    localparam int unsigned SYNC_STAGES = 1;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ;
    logic       dreqSenseLow;
    logic       rotatingPriority;
    logic       controllerDisable;
    logic [3:0] maskReg;
    logic [3:0] swRequestReg;
    logic       releaseGrant;
    logic       requestValid;
    logic [3:0] grantOneHot;
    logic [1:0] grantIndex;
    logic [3:0] clearSwRequest;
    logic [1:0] priorityPointer;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0] m_sync [SYNC_STAGES];
    int         m_phase = 0;     // 0 idle, 1 granted, 2 release
    bit         m_valid = 1'b0;
    int         m_idx = 0;
    int         m_ptr = 0;
    logic [3:0] m_clr = 4'b0;

    always #5 CLK = ~CLK;

    dma_priority_resolver #(
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .DREQ              (DREQ),
        .dreqSenseLow      (dreqSenseLow),
        .rotatingPriority  (rotatingPriority),
        .controllerDisable (controllerDisable),
        .maskReg           (maskReg),
        .swRequestReg      (swRequestReg),
        .releaseGrant      (releaseGrant),
        .requestValid      (requestValid),
        .grantOneHot       (grantOneHot),
        .grantIndex        (grantIndex),
        .clearSwRequest    (clearSwRequest),
        .priorityPointer   (priorityPointer)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applies the inputs present at a rising edge to the model.
    task automatic model_step();
        logic [3:0] dq;
        logic [3:0] eff;
        int         base;
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 4'b0;
            m_phase = 0;
            m_valid = 1'b0;
            m_idx   = 0;
            m_ptr   = 0;
            m_clr   = 4'b0;
            return;
        end
        dq    = m_sync[SYNC_STAGES-1];
        eff   = ((dq ^ {4{dreqSenseLow}}) & ~maskReg) | swRequestReg;
        m_clr = 4'b0;
        case (m_phase)
            0: if (eff != 4'b0 && !controllerDisable) begin
                base = rotatingPriority ? m_ptr : 0;
                for (int i = 0; i < 4; i++) begin
                    if (eff[(base + i) % 4]) begin
                        m_idx = (base + i) % 4;
                        break;
                    end
                end
                m_valid = 1'b1;
                m_phase = 1;
            end
            1: if (releaseGrant) begin
                m_valid = 1'b0;
                m_clr   = 4'(1 << m_idx);
                if (rotatingPriority) m_ptr = (m_idx + 1) % 4;
                m_phase = 2;
            end
            default: m_phase = 0;
        endcase
        if (!rotatingPriority) m_ptr = 0;
        for (int i = SYNC_STAGES - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = DREQ;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        chk("requestValid", 8'(requestValid), 8'(m_valid));
        chk("clearSwRequest", 8'(clearSwRequest), 8'(m_clr));
        chk("priorityPointer", 8'(priorityPointer), 8'(m_ptr));
        if (m_valid) begin
            chk("grantIndex", 8'(grantIndex), 8'(m_idx));
            chk("grantOneHot", 8'(grantOneHot), 8'(1 << m_idx));
        end
    endtask

    initial begin
        for (int i = 0; i < SYNC_STAGES; i++) m_sync[i] = 4'b0;
        RESET = 1'b1; DREQ = 4'b0; dreqSenseLow = 1'b0; rotatingPriority = 1'b0;
        controllerDisable = 1'b0; maskReg = 4'b0; swRequestReg = 4'b0; releaseGrant = 1'b0;

        // Reset and first grant
        tick();
        chk("rst_valid", 8'(requestValid), 8'h0);
        chk("rst_onehot", 8'(grantOneHot), 8'h0);
        chk("rst_ptr", 8'(priorityPointer), 8'h0);
        RESET = 1'b0; DREQ = 4'b0001;
        tick(); tick();
        chk("first_valid", 8'(requestValid), 8'h1);
        chk("first_idx", 8'(grantIndex), 8'h0);
        chk("first_onehot", 8'(grantOneHot), 8'h1);

        // Fixed priority, re-grant after 2-cycle gap
        releaseGrant = 1'b1; tick();
        chk("rel_valid", 8'(requestValid), 8'h0);
        releaseGrant = 1'b0; DREQ = 4'b1010;
        tick();
        chk("gap_valid", 8'(requestValid), 8'h0);
        tick();
        chk("fixed_idx", 8'(grantIndex), 8'h1);
        releaseGrant = 1'b1; tick();
        releaseGrant = 1'b0; tick(); tick();
        chk("fixed_regrant_valid", 8'(requestValid), 8'h1);
        chk("fixed_regrant_idx", 8'(grantIndex), 8'h1);
        chk("fixed_ptr", 8'(priorityPointer), 8'h0);

        // Rotating priority sweep with wrap
        RESET = 1'b1; rotatingPriority = 1'b1; DREQ = 4'b1111; tick();
        RESET = 1'b0; tick(); tick();
        chk("rot_idx0", 8'(grantIndex), 8'h0);
        for (int k = 0; k < 4; k++) begin
            releaseGrant = 1'b1; tick();
            chk("rot_ptr", 8'(priorityPointer), 8'((k + 1) % 4));
            releaseGrant = 1'b0; tick(); tick();
            chk("rot_valid", 8'(requestValid), 8'h1);
            chk("rot_idx", 8'(grantIndex), 8'((k + 1) % 4));
        end

        // Mask versus software request
        RESET = 1'b1; rotatingPriority = 1'b0; maskReg = 4'b0001; DREQ = 4'b0001; tick();
        RESET = 1'b0; tick(); tick(); tick();
        chk("masked_valid", 8'(requestValid), 8'h0);
        swRequestReg = 4'b0001; tick();
        chk("sw_valid", 8'(requestValid), 8'h1);
        chk("sw_idx", 8'(grantIndex), 8'h0);
        releaseGrant = 1'b1; tick();
        chk("sw_clear", 8'(clearSwRequest), 8'h1);
        releaseGrant = 1'b0; swRequestReg = 4'b0; tick();
        chk("sw_clear_off", 8'(clearSwRequest), 8'h0);

        // Polarity and disable
        RESET = 1'b1; maskReg = 4'b0; dreqSenseLow = 1'b1; DREQ = 4'b1110; tick();
        RESET = 1'b0; tick(); tick();
        chk("low_idx", 8'(grantIndex), 8'h0);
        controllerDisable = 1'b1; DREQ = 4'b1111; tick(); tick();
        chk("dis_hold_valid", 8'(requestValid), 8'h1);
        chk("dis_hold_idx", 8'(grantIndex), 8'h0);
        DREQ = 4'b0000; releaseGrant = 1'b1; tick();
        releaseGrant = 1'b0; tick(); tick(); tick();
        chk("dis_no_grant", 8'(requestValid), 8'h0);
        controllerDisable = 1'b0;

        // Reset while granted, with a coincident release
        RESET = 1'b1; dreqSenseLow = 1'b0; DREQ = 4'b0100; tick();
        RESET = 1'b0; tick(); tick();
        chk("ch2_idx", 8'(grantIndex), 8'h2);
        RESET = 1'b1; releaseGrant = 1'b1; tick();
        chk("rstg_valid", 8'(requestValid), 8'h0);
        chk("rstg_onehot", 8'(grantOneHot), 8'h0);
        chk("rstg_idx", 8'(grantIndex), 8'h0);
        chk("rstg_clear", 8'(clearSwRequest), 8'h0);
        chk("rstg_ptr", 8'(priorityPointer), 8'h0);
        RESET = 1'b0; releaseGrant = 1'b0;

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            RESET             = ($urandom_range(0, 199) == 0);
            DREQ              = 4'($urandom);
            maskReg           = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom);
            swRequestReg      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            controllerDisable = ($urandom_range(0, 9) == 0);
            releaseGrant      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) rotatingPriority = ~rotatingPriority;
            if ($urandom_range(0, 99) == 0) dreqSenseLow = ~dreqSenseLow;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
